// File: rtl/not_not_round_judge_pkg.sv
// Shared types for the NotNot round controller: FSM states, display control bundle, helpers.
package not_not_round_judge_pkg;

    localparam int unsigned NUM_COLOURS            = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100_000_000;
    localparam int unsigned DEFAULT_SCORE_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEXT,
        ST_SETTLE,
        ST_CLEAR,
        ST_DRAW,
        ST_WAIT,
        ST_HIT,
        ST_OVER
    } state_t;

    typedef struct packed {
        logic lfsr_enable;
        logic black;
        logic draw_enable;
        logic start;
        logic lose;
        logic round_active;
    } ctrl_t;

    // Control outputs held while sitting in a given state.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        c.lfsr_enable  = (s == ST_NEXT);
        c.black        = (s == ST_CLEAR);
        c.draw_enable  = (s == ST_DRAW);
        c.round_active = (s == ST_WAIT);
        c.lose         = (s == ST_OVER);
        c.start        = (s != ST_IDLE) && (s != ST_OVER);
        return c;
    endfunction

    function automatic logic is_onehot(input logic [NUM_COLOURS-1:0] v);
        return (v != '0) && ((v & (v - NUM_COLOURS'(1))) == '0);
    endfunction

endpackage

// File: rtl/not_not_round_judge_key_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse, one lane per input bit.
module key_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
            rise <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
        end
    end

endmodule

// File: rtl/not_not_round_judge.sv
// NotNot round controller: sequences each round, judges the player's keys, keeps score.
module not_not_round_judge
    import not_not_round_judge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned SCORE_W        = DEFAULT_SCORE_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_btn,
    input  logic [NUM_COLOURS-1:0] key_in,
    input  logic [NUM_COLOURS-1:0] answer_mask,
    input  logic                   done_draw,
    input  logic                   done_draw_black,
    output logic                   lfsr_enable,
    output logic                   black,
    output logic                   draw_enable,
    output logic                   start,
    output logic                   lose,
    output logic                   round_active,
    output logic [SCORE_W-1:0]     score
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [NUM_COLOURS-1:0] key_edge;
    logic                   start_edge;
    state_t                 state;
    ctrl_t                  ctrl;
    logic [TIMER_W-1:0]     timer;
    logic [NUM_COLOURS-1:0] mask_q;

    key_sync_edge #(.WIDTH(NUM_COLOURS)) u_key_sync (
        .clock (clock),
        .reset (reset),
        .raw   (key_in),
        .rise  (key_edge)
    );

    key_sync_edge #(.WIDTH(1)) u_start_sync (
        .clock (clock),
        .reset (reset),
        .raw   (start_btn),
        .rise  (start_edge)
    );

    assign lfsr_enable  = ctrl.lfsr_enable;
    assign black        = ctrl.black;
    assign draw_enable  = ctrl.draw_enable;
    assign start        = ctrl.start;
    assign lose         = ctrl.lose;
    assign round_active = ctrl.round_active;

    // Round FSM; ctrl is loaded with the decode of the state being entered so outputs are flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            ctrl   <= '0;
            timer  <= '0;
            mask_q <= '0;
            score  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        score <= '0;
                        state <= ST_NEXT;
                        ctrl  <= ctrl_for(ST_NEXT);
                    end
                end
                ST_NEXT: begin
                    state <= ST_SETTLE;
                    ctrl  <= ctrl_for(ST_SETTLE);
                end
                ST_SETTLE: begin
                    mask_q <= answer_mask;
                    state  <= ST_CLEAR;
                    ctrl   <= ctrl_for(ST_CLEAR);
                end
                ST_CLEAR: begin
                    if (done_draw_black) begin
                        state <= ST_DRAW;
                        ctrl  <= ctrl_for(ST_DRAW);
                    end
                end
                ST_DRAW: begin
                    if (done_draw) begin
                        timer <= TIMER_W'(TIMEOUT_CYCLES - 1);
                        state <= ST_WAIT;
                        ctrl  <= ctrl_for(ST_WAIT);
                    end
                end
                ST_WAIT: begin
                    // A press always wins over the timeout, even on the final cycle.
                    if (key_edge != '0) begin
                        if (is_onehot(key_edge) && ((key_edge & mask_q) != '0)) begin
                            state <= ST_HIT;
                            ctrl  <= ctrl_for(ST_HIT);
                        end else begin
                            state <= ST_OVER;
                            ctrl  <= ctrl_for(ST_OVER);
                        end
                    end else if (timer == '0) begin
                        if (mask_q == '0) begin
                            state <= ST_HIT;
                            ctrl  <= ctrl_for(ST_HIT);
                        end else begin
                            state <= ST_OVER;
                            ctrl  <= ctrl_for(ST_OVER);
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_HIT: begin
                    if (score != SCORE_MAX) begin
                        score <= score + SCORE_W'(1);
                    end
                    state <= ST_NEXT;
                    ctrl  <= ctrl_for(ST_NEXT);
                end
                ST_OVER: begin
                    if (start_edge) begin
                        score <= '0;
                        state <= ST_NEXT;
                        ctrl  <= ctrl_for(ST_NEXT);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ctrl  <= '0;
                end
            endcase
        end
    end

endmodule
